vblank_write_arbiter: RTL
=========================

// Module: vblank_write_arbiter
// PURPOSE
//  Schedules game-state writes (ball, paddles, score) into the shared sprite/position
//  registers so they occur only during vertical blanking, which prevents tearing.
//  - Watches the row count from the VGA timing generator.
//  - Opens a write window during vblank.
//  - Round-robin arbitrates the single write port among N_REQ requesters.
//  - Emits a once-per-frame tick for the game-logic FSMs.
// PARAMETERS
//  N_REQ     4    number of requesters (2..8)
//  VB_FIRST  480  first row of the write window (inclusive)
//  VB_LAST   519  last row of the write window (inclusive); VB_LAST <= 520
//  MAX_HOLD  64   maximum cycles one grant may be held (>= 2)
// PORTS
//  CLOCK_50    in   1      system clock, 50 MHz
//  reset       in   1      reset: asynchronous assert, active-low (0 = reset)
//  row         in   10     current row from the VGA timing generator (0..520)
//  req         in   N_REQ  req[i]=1: requester i wants the write port; level, held until done
//  done        in   N_REQ  done[i]=1 for one cycle: requester i has finished; sampled only while gnt[i]=1
//  gnt         out  N_REQ  one-hot (or zero) grant of the write port
//  window      out  1      1 while writes are permitted
//  frame_tick  out  1      one-cycle pulse on the rising edge of window
//  err         out  2      sticky per frame:
//                            [0] a grant hit MAX_HOLD
//                            [1] window closed with req pending and not served
// BEHAVIOUR
//  Reset (async, reset=0): gnt=0, window=0, frame_tick=0, err=0, rr_ptr=0, hold_cnt=0,
//   state=CLOSED. Applies immediately mid-grant; gnt drops with no handshake.
//  Window
//   - window <= (row >= VB_FIRST) && (row <= VB_LAST); registered, 1-cycle latency from row.
//   - frame_tick = window & ~window_q. Rows wrap 520 -> 0, so the window closes after VB_LAST.
//   - If reset is released while row is inside the window, window rises 1 cycle later
//     and frame_tick fires.
//  FSM (state registered; gnt registered)
//   - CLOSED: gnt=0. Go to ARB when window=1.
//   - ARB:
//       - window=0 -> CLOSED.
//       - else if |req: choose the first set req[j] at or after rr_ptr, modulo N_REQ.
//         Next cycle gnt=1<<j, hold_cnt=0, go to GRANT.
//       - else stay in ARB.
//   - GRANT (gnt[j]=1): hold_cnt increments each cycle. Release when any of:
//       - done[j]
//       - req[j]==0
//       - hold_cnt==MAX_HOLD-1 (this also sets err[0])
//       - window==0
//     On release: gnt=0 next cycle; rr_ptr=(j+1) mod N_REQ; next state is ARB,
//     or CLOSED if window==0.
//  Grant latency and spacing
//   - Minimum latency from req to gnt is 2 cycles (ARB sample, then register).
//   - At least one gnt=0 cycle always separates consecutive grants.
//  Other rules
//   - A requester only ever sees gnt while window=1 or on the single cycle after
//     window falls; writers must qualify writes with gnt & window.
//   - err[1] is set on the falling edge of window if any req bit is 1.
//   - err clears on frame_tick. When a set and a clear coincide, set wins.
//   - done[i] is ignored when gnt[i]=0.
//   - req and done both high in the same cycle means release.
//   - rr_ptr wraps N_REQ-1 -> 0.
// CONFIGURATION
//  FRAME_COUNT_EN defined:
//   - adds output frame_count [15:0].
//   - reset value 0; increments on each frame_tick; wraps 0xFFFF -> 0.
//  FRAME_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset low with row=500 and req=4'b1111; release reset -> window=1 and frame_tick pulse
//     one cycle after release; first gnt=4'b0001 two cycles later.
//  2. req=4'b1111 held; each grant ends with a done pulse 3 cycles after gnt ->
//     gnt order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
//  3. req[2]=1 and done never asserted -> gnt[2] high exactly 64 cycles, err[0]=1,
//     then rr_ptr=3; the next frame_tick clears err[0].
//  4. Grant active when row goes 519 -> 520 -> gnt=0 one cycle after window falls;
//     err[1]=1 if req is still high; no grant while row is 0..479.
//  5. Assert reset during GRANT -> gnt, window and err go to 0 asynchronously;
//     after release arbitration restarts at requester 0.
//  6. FRAME_COUNT_EN, 3 full frames (3*521*1600 cycles) from reset -> frame_count=3;
//     preload to 0xFFFF and tick -> frame_count=0.

Source files
------------

// File: rtl/vblank_write_arbiter.sv
// Vertical-blank write arbiter: opens a write window on rows VB_FIRST..VB_LAST and
// round-robins one write port among N_REQ requesters. Optional macro: FRAME_COUNT_EN.
module vblank_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int VB_FIRST = 480,
  parameter int VB_LAST  = 519,
  parameter int MAX_HOLD = 64
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [9:0]       row,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             window,
  output logic             frame_tick,
  output logic [1:0]       err,
`ifdef FRAME_COUNT_EN
  output logic [15:0]      frame_count,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held until the write is finished; gnt[i] is a
  // registered one-hot grant; done[i] is a 1-cycle pulse honoured only while gnt[i]=1.
  // A grant also ends when req[i] drops, the hold limit is reached, or the window closes.

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    ARB    = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t        state;
  logic          window_q;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [HW-1:0] hold_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   scan_idx;
  logic          hold_max;
  logic          release_now;
  logic [IW-1:0] ptr_after;

  assign state_dbg  = state;
  assign frame_tick = window & ~window_q;

  // Scan offsets from the far end down so the requester closest to rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N_REQ)) scan_idx = scan_idx - (IW+1)'(N_REQ);
      if (req[scan_idx[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[IW-1:0];
      end
    end
  end

  assign hold_max    = (hold_cnt == HW'(MAX_HOLD - 1));
  assign release_now = done[gnt_idx] | ~req[gnt_idx] | hold_max | ~window;
  assign ptr_after   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      window   <= 1'b0;
      window_q <= 1'b0;
    end else begin
      window   <= (row >= 10'(VB_FIRST)) && (row <= 10'(VB_LAST));
      window_q <= window;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state    <= CLOSED;
      gnt      <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        CLOSED: begin
          gnt <= '0;
          if (window) state <= ARB;
        end
        ARB: begin
          if (!window) begin
            state <= CLOSED;
          end else if (pick_valid) begin
            gnt      <= N_REQ'(1) << pick_idx;
            gnt_idx  <= pick_idx;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt    <= '0;
            rr_ptr <= ptr_after;
            state  <= window ? ARB : CLOSED;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= CLOSED;
        end
      endcase
    end
  end

  // Sets are written after the frame clear so a coinciding set survives.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      err <= 2'b00;
    end else begin
      if (frame_tick) err <= 2'b00;
      if (state == GRANT && hold_max) err[0] <= 1'b1;
      if (window_q && !window && (|req)) err[1] <= 1'b1;
    end
  end

`ifdef FRAME_COUNT_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) frame_count <= 16'd0;
    else if (frame_tick) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule
